round_key_sequencer: RTL and testbench
======================================

Name: round_key_sequencer

Overview:
- Sits directly downstream of the 256-bit key expansion block.
- Waits out the expansion pipeline after a new initial key is loaded, then snapshots the flattened 15x128-bit round-key bundle.
- On request, streams the round keys one per handshake, with an index, to the multicycle AES-256 cipher round engine.
- Decouples the cipher from expansion timing and lets the next key be loaded while the cipher finishes a block.

Parameters:
- NUM_ROUNDS, 14, AES rounds; NUM_ROUNDS+1 round keys are held.
- RK_W, 128, round-key width in bits.
- EXP_LATENCY, 7, cycles from key_load_i to a stable round_keys_i bundle; must be >= 1.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-low reset.
- key_load_i  in  1  pulse; a new initial key enters expansion this cycle.
- round_keys_i  in  RK_W*(NUM_ROUNDS+1)  flattened bundle from expansion; key 0 occupies the MSBs.
- start_i  in  1  request to stream one full key sequence.
- start_ready_o  out  1  high only in READY.
- rk_o  out  RK_W  current round key.
- rk_idx_o  out  4  index of rk_o.
- rk_v_o  out  1  rk_o is valid.
- rk_ready_i  in  1  consumer accepts rk_o.
- rk_last_o  out  1  rk_o is the final key of the sequence.
- keys_valid_o  out  1  snapshot holds a complete, current key set.
- done_o  out  1  one-cycle pulse after the last key is accepted.

Behaviour:
- States: EMPTY, EXPANDING, READY, STREAM.
- Reset (async assert, sync release): state=EMPTY, counter=0, index=0. All outputs 0; snapshot contents don't-care.
- Any state, key_load_i=1: go to EXPANDING, counter=EXP_LATENCY-1, keys_valid_o=0. An in-flight STREAM is aborted without a done_o pulse. key_load_i has priority over start_i and over a handshake in the same cycle.
- EXPANDING, counter>0: decrement.
- EXPANDING, counter==0: capture round_keys_i into the snapshot on this edge, go to READY, keys_valid_o=1 from the next cycle.
- READY: start_ready_o=1. start_i=1 -> STREAM with index 0 (reverse mode: NUM_ROUNDS). start_i in EMPTY, EXPANDING or STREAM is ignored, not queued.
- STREAM outputs: rk_v_o=1; rk_o=snapshot[index], a registered mux output; rk_idx_o=index. rk_o and rk_idx_o are held stable while rk_v_o=1 and rk_ready_i=0.
- STREAM handshake (rk_v_o & rk_ready_i): advance the index. Throughput is one key per cycle with rk_ready_i held high.
- rk_last_o=1 when index==NUM_ROUNDS (reverse mode: index==0).
- Handshake with rk_last_o=1: go to READY, pulse done_o next cycle. start_i is accepted again from the cycle after return to READY.
- The index never wraps. Out-of-range indices are unreachable; assertions cover this.
- Minimum latency: start_i -> first rk_v_o is 1 cycle. key_load_i -> keys_valid_o is EXP_LATENCY+1 cycles.
- Outside STREAM: rk_v_o=0 and rk_o=0.

Optional Feature:
- Macro RK_DECRYPT_ORDER_EN.
- When defined: adds input dir_i (1 bit), sampled with start_i. dir_i=1 streams keys NUM_ROUNDS down to 0 for the inverse cipher; dir_i=0 streams forward.
- When undefined: no dir_i port, forward order only, and reverse-order logic is absent.

Decomposition:
- Shared package aes_pkg: AES_NR=14, AES_RK_W=128, typedef rk_t (logic [0:127]), typedef rk_idx_t (logic [3:0]), enum rks_state_e {EMPTY, EXPANDING, READY, STREAM}.
- One natural sub-module, round_key_bank: NUM_ROUNDS+1 x RK_W snapshot registers with a capture-enable and a registered indexed read.
- The FSM, latency counter and handshake stay in the top module.

Test Plan:
- Reset, then pulse key_load_i with bundle word k = 128'hk repeated per index -> keys_valid_o rises 8 cycles later; start_ready_o=1.
- start_i with rk_ready_i tied 1 -> rk_idx_o = 0..14 on consecutive cycles, rk_o matches bundle slices, rk_last_o only at idx 14, done_o one cycle after.
- Random rk_ready_i backpressure (~50%) -> rk_o and rk_idx_o stable while stalled; exactly 15 handshakes; no duplicate or skipped index.
- key_load_i at idx 6 mid-stream -> rk_v_o drops next cycle, no done_o, state EXPANDING; after 8 cycles, new bundle values appear on a fresh stream.
- key_load_i and start_i in the same cycle from READY -> no stream starts; keys_valid_o=0 until reload completes.
- RK_DECRYPT_ORDER_EN defined, dir_i=1 -> rk_idx_o = 14..0, rk_last_o at idx 0; dir_i=0 -> forward order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and sizes.
// Used by the round-key sequencer, its interface and its key bank.
package aes_pkg;
  localparam int AES_NR   = 14;
  localparam int AES_RK_W = 128;

  typedef logic [0:127] rk_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [1:0] {
    EMPTY,
    EXPANDING,
    READY,
    STREAM
  } rks_state_e;
endpackage

// File: rtl/round_key_sequencer_if.sv
// Round-key stream handshake towards the cipher round engine.
// master: rk_o, rk_idx_o, rk_v_o, rk_last_o out; rk_ready_i in.
interface round_key_sequencer_if
  import aes_pkg::*;
#(
  parameter int RK_W = AES_RK_W
);
  logic [RK_W-1:0] rk_o;
  rk_idx_t         rk_idx_o;
  logic            rk_v_o;
  logic            rk_ready_i;
  logic            rk_last_o;

  modport master (
    output rk_o, rk_idx_o, rk_v_o, rk_last_o,
    input  rk_ready_i
  );

  modport slave (
    input  rk_o, rk_idx_o, rk_v_o, rk_last_o,
    output rk_ready_i
  );
endinterface

// File: rtl/round_key_bank.sv
// Snapshot of NUM_ROUNDS+1 round keys with a registered indexed read.
// Ports: cap_en_i/bundle_i capture, rd_en_i/rd_idx_i -> rd_o next cycle.
module round_key_bank
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int RK_W       = AES_RK_W
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cap_en_i,
  input  logic [RK_W*(NUM_ROUNDS+1)-1:0] bundle_i,
  input  logic                           rd_en_i,
  input  rk_idx_t                        rd_idx_i,
  output logic [RK_W-1:0]                rd_o
);
  localparam int N = NUM_ROUNDS + 1;

  logic [RK_W-1:0] mem_q [N];
  logic [RK_W-1:0] rd_q;

  // Key 0 sits in the MSBs of the flattened bundle.
  always_ff @(posedge clk_i) begin
    if (cap_en_i) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= bundle_i[RK_W*(N-i)-1 -: RK_W];
      end
    end
  end

  // Read port returns zero whenever no stream is active.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= mem_q[rd_idx_i];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_o = rd_q;
endmodule

// File: rtl/round_key_sequencer.sv
// Snapshots expanded AES round keys and streams them to the cipher.
// Ports: clk_i, reset_i (async low), key_load_i, round_keys_i,
// start_i, start_ready_o, keys_valid_o, done_o, rk_if (master).
// Option RK_DECRYPT_ORDER_EN adds dir_i for reverse key order.
module round_key_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES_NR,
  parameter int RK_W        = AES_RK_W,
  parameter int EXP_LATENCY = 7
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           key_load_i,
  input  logic [RK_W*(NUM_ROUNDS+1)-1:0] round_keys_i,
  input  logic                           start_i,
`ifdef RK_DECRYPT_ORDER_EN
  input  logic                           dir_i,
`endif
  output logic                           start_ready_o,
  output logic                           keys_valid_o,
  output logic                           done_o,
  round_key_sequencer_if.master          rk_if
);
  localparam int CNT_W =
    (EXP_LATENCY > 1) ? $clog2(EXP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(EXP_LATENCY - 1);
  localparam rk_idx_t LAST_IDX = rk_idx_t'(NUM_ROUNDS);

  rks_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rk_idx_t idx_q, idx_d;
  rk_idx_t end_idx_d;
  logic kv_q, kv_d;
  logic done_q, done_d;
  logic sr_q, v_q, last_q;
  logic cap_en, hs;
`ifdef RK_DECRYPT_ORDER_EN
  logic rev_q, rev_d;
`endif

  assign hs = v_q & rk_if.rk_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    cap_en  = 1'b0;
`ifdef RK_DECRYPT_ORDER_EN
    rev_d   = rev_q;
`endif
    // A reload wins over start and over a pending handshake.
    if (key_load_i) begin
      state_d = EXPANDING;
      cnt_d   = CNT_INIT;
      kv_d    = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: ;
        EXPANDING: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cap_en  = 1'b1;
            state_d = READY;
            kv_d    = 1'b1;
          end
        end
        READY: begin
          if (start_i) begin
            state_d = STREAM;
`ifdef RK_DECRYPT_ORDER_EN
            rev_d = dir_i;
            idx_d = dir_i ? LAST_IDX : '0;
`else
            idx_d = '0;
`endif
          end
        end
        STREAM: begin
          if (hs) begin
            if (last_q) begin
              state_d = READY;
              done_d  = 1'b1;
            end else begin
`ifdef RK_DECRYPT_ORDER_EN
              idx_d = rev_q ? idx_q - 1'b1
                            : idx_q + 1'b1;
`else
              idx_d = idx_q + 1'b1;
`endif
            end
          end
        end
      endcase
    end
  end

`ifdef RK_DECRYPT_ORDER_EN
  assign end_idx_d = rev_d ? '0 : LAST_IDX;
`else
  assign end_idx_d = LAST_IDX;
`endif

  // Outputs are registered from the next-state view.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      idx_q   <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= 1'b0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
`ifdef RK_DECRYPT_ORDER_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
      sr_q    <= (state_d == READY);
      v_q     <= (state_d == STREAM);
      last_q  <= (state_d == STREAM) &&
                 (idx_d == end_idx_d);
`ifdef RK_DECRYPT_ORDER_EN
      rev_q   <= rev_d;
`endif
    end
  end

  round_key_bank #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RK_W       (RK_W)
  ) u_bank (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .cap_en_i (cap_en),
    .bundle_i (round_keys_i),
    .rd_en_i  (state_d == STREAM),
    .rd_idx_i (idx_d),
    .rd_o     (rk_if.rk_o)
  );

  assign rk_if.rk_idx_o  = idx_q;
  assign rk_if.rk_v_o    = v_q;
  assign rk_if.rk_last_o = last_q;
  assign start_ready_o   = sr_q;
  assign keys_valid_o    = kv_q;
  assign done_o          = done_q;

  a_idx_range: assert property (
    @(posedge clk_i) disable iff (!reset_i)
    idx_q <= LAST_IDX
  );

  a_hold_on_stall: assert property (
    @(posedge clk_i) disable iff (!reset_i)
    (v_q && !rk_if.rk_ready_i && !key_load_i)
      |=> (v_q && $stable(idx_q))
  );
endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed testbench for round_key_sequencer.
// Each task drives one scenario and checks its own results inline.
module tb_round_key_sequencer;
  import aes_pkg::*;

  localparam int W = 128;
  localparam int N = 15;

  logic clk = 1'b0;
  logic reset_i;
  logic key_load_i;
  logic start_i;
  logic [W*N-1:0] round_keys_i;
  logic start_ready_o;
  logic keys_valid_o;
  logic done_o;
`ifdef RK_DECRYPT_ORDER_EN
  logic dir_i;
`endif

  int tests_run = 0;
  int fails = 0;

  round_key_sequencer_if rk_if ();

  round_key_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .key_load_i    (key_load_i),
    .round_keys_i  (round_keys_i),
    .start_i       (start_i),
`ifdef RK_DECRYPT_ORDER_EN
    .dir_i         (dir_i),
`endif
    .start_ready_o (start_ready_o),
    .keys_valid_o  (keys_valid_o),
    .done_o        (done_o),
    .rk_if         (rk_if)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] kw(
    input logic [7:0] seed, input int i);
    logic [7:0] b;
    b = seed + 8'(i);
    return {16{b}};
  endfunction

  task automatic set_bundle(input logic [7:0] seed);
    for (int i = 0; i < N; i++)
      round_keys_i[W*(N-i)-1 -: W] = kw(seed, i);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks until keys_valid_o rises; n counts ticks since key_load_i.
  task automatic wait_keys(input bit poke,
                           output int n, output bit stray);
    n = 1;
    stray = 1'b0;
    while (keys_valid_o !== 1'b1 && n < 30) begin
      if (poke && n == 3) start_i = 1'b1;
      tick;
      start_i = 1'b0;
      n++;
      if (rk_if.rk_v_o !== 1'b0 || done_o !== 1'b0)
        stray = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    key_load_i = 1'b0;
    start_i = 1'b0;
    rk_if.rk_ready_i = 1'b0;
    round_keys_i = '0;
    tick;
    tick;
    tests_run++;
    if ({rk_if.rk_v_o, start_ready_o, keys_valid_o, done_o,
         rk_if.rk_last_o, rk_if.rk_idx_o} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0",
        {rk_if.rk_v_o, start_ready_o, keys_valid_o, done_o,
         rk_if.rk_last_o, rk_if.rk_idx_o});
    end
    tests_run++;
    if (rk_if.rk_o !== '0) begin
      fails++;
      $display("FAIL reset_rk got %h want 0", rk_if.rk_o);
    end
    reset_i = 1'b1;
    tick;
    tests_run++;
    if ({rk_if.rk_v_o, start_ready_o, keys_valid_o} !== 3'b0) begin
      fails++;
      $display("FAIL empty_after_reset got %b want 000",
        {rk_if.rk_v_o, start_ready_o, keys_valid_o});
    end
  endtask

  task automatic test_load(input logic [7:0] seed);
    int n;
    bit stray;
    set_bundle(seed);
    key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    wait_keys(1'b1, n, stray);
    tests_run++;
    if (n != 8) begin
      fails++;
      $display("FAIL load_latency got %0d want 8", n);
    end
    tests_run++;
    if (stray !== 1'b0) begin
      fails++;
      $display("FAIL load_no_stream got %b want 0", stray);
    end
    tests_run++;
    if (start_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL load_ready got %b want 1", start_ready_o);
    end
  endtask

  task automatic test_stream_fwd(input logic [7:0] seed);
    rk_if.rk_ready_i = 1'b1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (rk_if.rk_v_o !== 1'b1 ||
          rk_if.rk_idx_o !== 4'(i)) begin
        fails++;
        $display("FAIL fwd_idx got v=%b idx=%0d want v=1 idx=%0d",
          rk_if.rk_v_o, rk_if.rk_idx_o, i);
      end
      tests_run++;
      if (rk_if.rk_o !== kw(seed, i)) begin
        fails++;
        $display("FAIL fwd_key[%0d] got %h want %h",
          i, rk_if.rk_o, kw(seed, i));
      end
      tests_run++;
      if (rk_if.rk_last_o !== (i == N - 1)) begin
        fails++;
        $display("FAIL fwd_last[%0d] got %b", i, rk_if.rk_last_o);
      end
      tests_run++;
      if (start_ready_o !== 1'b0 || done_o !== 1'b0) begin
        fails++;
        $display("FAIL fwd_busy got ready=%b done=%b want 0 0",
          start_ready_o, done_o);
      end
      tick;
    end
    tests_run++;
    if ({done_o, rk_if.rk_v_o, start_ready_o, rk_if.rk_o == '0}
        !== 4'b1011) begin
      fails++;
      $display("FAIL fwd_done got %b want 1011",
        {done_o, rk_if.rk_v_o, start_ready_o, rk_if.rk_o == '0});
    end
    tick;
    tests_run++;
    if (done_o !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse got %b want 0", done_o);
    end
  endtask

  task automatic test_backpressure(input logic [7:0] seed);
    int exp_i, hs;
    bit got_done, stalled, r;
    logic [3:0] p_idx;
    logic [W-1:0] p_rk;
    exp_i = 0;
    hs = 0;
    got_done = 1'b0;
    stalled = 1'b0;
    p_idx = '0;
    p_rk = '0;
    rk_if.rk_ready_i = 1'b0;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (done_o === 1'b1) begin
        got_done = 1'b1;
      end else if (rk_if.rk_v_o === 1'b1 && exp_i < N) begin
        tests_run++;
        if (rk_if.rk_idx_o !== 4'(exp_i) ||
            rk_if.rk_o !== kw(seed, exp_i)) begin
          fails++;
          $display("FAIL bp_key got idx=%0d want idx=%0d",
            rk_if.rk_idx_o, exp_i);
        end
        if (stalled) begin
          tests_run++;
          if (rk_if.rk_idx_o !== p_idx || rk_if.rk_o !== p_rk) begin
            fails++;
            $display("FAIL bp_hold got idx=%0d want idx=%0d",
              rk_if.rk_idx_o, p_idx);
          end
        end
        p_idx = rk_if.rk_idx_o;
        p_rk = rk_if.rk_o;
        r = 1'($urandom_range(0, 1));
        rk_if.rk_ready_i = r;
        stalled = !r;
        if (r) begin
          exp_i++;
          hs++;
        end
      end else begin
        tests_run++;
        fails++;
        $display("FAIL bp_valid got v=%b at exp idx %0d",
          rk_if.rk_v_o, exp_i);
        got_done = 1'b1;
      end
      tick;
    end
    rk_if.rk_ready_i = 1'b0;
    tests_run++;
    if (hs != N || !got_done) begin
      fails++;
      $display("FAIL bp_count got hs=%0d done=%b want 15 1",
        hs, got_done);
    end
  endtask

  task automatic test_abort(input logic [7:0] seed_new);
    int n;
    bit stray;
    rk_if.rk_ready_i = 1'b1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    tests_run++;
    if (rk_if.rk_v_o !== 1'b1 || rk_if.rk_idx_o !== 4'd6) begin
      fails++;
      $display("FAIL abort_pos got v=%b idx=%0d want 1 6",
        rk_if.rk_v_o, rk_if.rk_idx_o);
    end
    set_bundle(seed_new);
    key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    tests_run++;
    if ({rk_if.rk_v_o, done_o, keys_valid_o, start_ready_o,
         rk_if.rk_o == '0} !== 5'b00001) begin
      fails++;
      $display("FAIL abort_drop got %b want 00001",
        {rk_if.rk_v_o, done_o, keys_valid_o, start_ready_o,
         rk_if.rk_o == '0});
    end
    wait_keys(1'b0, n, stray);
    tests_run++;
    if (n != 8 || stray) begin
      fails++;
      $display("FAIL abort_reload got n=%0d stray=%b want 8 0",
        n, stray);
    end
    test_stream_fwd(seed_new);
  endtask

  task automatic test_load_start_same(input logic [7:0] seed);
    int n;
    bit stray;
    set_bundle(seed);
    key_load_i = 1'b1;
    start_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    start_i = 1'b0;
    tests_run++;
    if ({rk_if.rk_v_o, start_ready_o, keys_valid_o} !== 3'b0) begin
      fails++;
      $display("FAIL ld_st_same got %b want 000",
        {rk_if.rk_v_o, start_ready_o, keys_valid_o});
    end
    wait_keys(1'b0, n, stray);
    tests_run++;
    if (n != 8 || stray) begin
      fails++;
      $display("FAIL ld_st_reload got n=%0d stray=%b want 8 0",
        n, stray);
    end
    test_stream_fwd(seed);
  endtask

`ifdef RK_DECRYPT_ORDER_EN
  task automatic test_reverse(input logic [7:0] seed);
    rk_if.rk_ready_i = 1'b1;
    dir_i = 1'b1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    dir_i = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      tests_run++;
      if (rk_if.rk_v_o !== 1'b1 ||
          rk_if.rk_idx_o !== 4'(i) ||
          rk_if.rk_o !== kw(seed, i)) begin
        fails++;
        $display("FAIL rev_key got idx=%0d want idx=%0d",
          rk_if.rk_idx_o, i);
      end
      tests_run++;
      if (rk_if.rk_last_o !== (i == 0)) begin
        fails++;
        $display("FAIL rev_last[%0d] got %b", i, rk_if.rk_last_o);
      end
      tick;
    end
    tests_run++;
    if (done_o !== 1'b1 || start_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL rev_done got %b want 11",
        {done_o, start_ready_o});
    end
    tick;
  endtask
`endif

  initial begin
`ifdef RK_DECRYPT_ORDER_EN
    dir_i = 1'b0;
`endif
    test_reset;
    test_load(8'h00);
    test_stream_fwd(8'h00);
    test_backpressure(8'h00);
    test_abort(8'h50);
    test_load_start_same(8'hA0);
`ifdef RK_DECRYPT_ORDER_EN
    test_reverse(8'hA0);
    test_stream_fwd(8'hA0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
